// File: rtl/bus_pkg.sv
// Shared definitions for the device crossbar: handshake states, default
// address map and the wait-counter sizing helper.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // Slave 0 occupies the least significant 32 bits of each packed map.
  localparam logic [127:0] DEFAULT_SLAVE_BASE =
    {32'h0010_0200, 32'h0010_0100, 32'h0010_0000, 32'h0000_0000};
  localparam logic [127:0] DEFAULT_SLAVE_SIZE =
    {32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0010_0000};

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Combinational window decode: first (lowest index) slave whose
// [base, base+size) window contains the address, plus the in-window offset.
module addr_decode
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = DEFAULT_SLAVE_SIZE
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  index,
  output logic [ADDR_W-1:0] offset
);

  logic [ADDR_W:0] addr_x;
  logic [ADDR_W:0] base_x;
  logic [ADDR_W:0] limit_x;

  assign addr_x = {1'b0, addr};

  // One extra bit keeps a window ending exactly at 2^ADDR_W from wrapping.
  // Scanning downwards lets the lowest matching index overwrite the result.
  always_comb begin
    hit     = 1'b0;
    index   = '0;
    offset  = '0;
    base_x  = '0;
    limit_x = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      base_x  = {1'b0, SLAVE_BASE[i*ADDR_W +: ADDR_W]};
      limit_x = base_x + {1'b0, SLAVE_SIZE[i*ADDR_W +: ADDR_W]};
      if ((addr_x >= base_x) && (addr_x < limit_x)) begin
        hit    = 1'b1;
        index  = IDX_W'(i);
        offset = addr - base_x[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/device_xbar.sv
// Single-master to N-slave crossbar with a four-phase strobe/ack handshake,
// unmapped-address and timeout bus errors, and abort on strobe release.
module device_xbar
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = DEFAULT_SLAVE_SIZE,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         master_ds,
  input  logic [ADDR_W-1:0]            master_addr,
  input  logic [DATA_W-1:0]            master_write,
  output logic [DATA_W-1:0]            master_read,
  output logic                         master_ack,
  output logic                         master_berr,
  output logic [NUM_SLAVES-1:0]        slave_ds,
  output logic [ADDR_W-1:0]            slave_addr,
  output logic [DATA_W-1:0]            slave_write,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_read,
  input  logic [NUM_SLAVES-1:0]        slave_ack,
  output logic                         busy
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW    = cnt_width(TIMEOUT);

  state_e            state;
  logic [IDX_W-1:0]  sel;
  logic [CW-1:0]     wait_cnt;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_index;
  logic [ADDR_W-1:0] dec_offset;

  addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SIZE (SLAVE_SIZE)
  ) u_decode (
    .addr   (master_addr),
    .hit    (dec_hit),
    .index  (dec_index),
    .offset (dec_offset)
  );

  // Handshake: the master holds master_ds until it sees master_ack or
  // master_berr, then releases it; the flag drops the cycle after release.
  // A slave completes by raising slave_ack while its slave_ds is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel         <= '0;
      wait_cnt    <= '0;
      slave_ds    <= '0;
      slave_addr  <= '0;
      slave_write <= '0;
      master_read <= '0;
      master_ack  <= 1'b0;
      master_berr <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (master_ds) begin
            busy <= 1'b1;
            if (dec_hit) begin
              sel         <= dec_index;
              slave_addr  <= dec_offset;
              slave_write <= master_write;
              slave_ds    <= NUM_SLAVES'(1) << dec_index;
              wait_cnt    <= '0;
              state       <= ST_ACCESS;
            end else begin
              master_berr <= 1'b1;
              state       <= ST_ERR;
            end
          end
        end

        // Abort beats ack, and ack beats timeout on the same cycle.
        ST_ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!master_ds) begin
            slave_ds <= '0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (slave_ack[sel]) begin
            master_read <= slave_read[sel*DATA_W +: DATA_W];
            slave_ds    <= '0;
            master_ack  <= 1'b1;
            state       <= ST_ACK;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            slave_ds    <= '0;
            master_berr <= 1'b1;
            state       <= ST_ERR;
          end
        end

        ST_ACK: begin
          if (!master_ds) begin
            master_ack <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        ST_ERR: begin
          if (!master_ds) begin
            master_berr <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_device_xbar.sv
// Self-checking bench for device_xbar: directed scenarios plus randomized
// transfers checked against an address-map model of the crossbar.
module tb_device_xbar;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int TO = 8;

  logic               clk;
  logic               reset;
  logic               master_ds;
  logic [AW-1:0]      master_addr;
  logic [DW-1:0]      master_write;
  logic [DW-1:0]      master_read;
  logic               master_ack;
  logic               master_berr;
  logic [NS-1:0]      slave_ds;
  logic [AW-1:0]      slave_addr;
  logic [DW-1:0]      slave_write;
  logic [NS*DW-1:0]   slave_read;
  logic [NS-1:0]      slave_ack;
  logic               busy;

  int n_cmp;
  int n_bad;
  logic [DW-1:0] last_read;

  // Window map: slave 1 at 0x100100, slave 2 at 0x100200, slave 3 at 0x100000.
  longint unsigned m_base [NS] = '{64'h0, 64'h10_0100, 64'h10_0200, 64'h10_0000};
  longint unsigned m_size [NS] = '{64'h10_0000, 64'h100, 64'h100, 64'h100};

  device_xbar #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SLAVE_BASE ({32'h0010_0000, 32'h0010_0200, 32'h0010_0100, 32'h0000_0000}),
    .SLAVE_SIZE ({32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0010_0000}),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .master_ds    (master_ds),
    .master_addr  (master_addr),
    .master_write (master_write),
    .master_read  (master_read),
    .master_ack   (master_ack),
    .master_berr  (master_berr),
    .slave_ds     (slave_ds),
    .slave_addr   (slave_addr),
    .slave_write  (slave_write),
    .slave_read   (slave_read),
    .slave_ack    (slave_ack),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_decode(input logic [AW-1:0] a, output bit hit,
                                       output int idx, output logic [AW-1:0] off);
    longint unsigned av;
    av  = 64'(a);
    hit = 0;
    idx = 0;
    off = '0;
    for (int i = 0; i < NS; i++) begin
      if (!hit && av >= m_base[i] && av < m_base[i] + m_size[i]) begin
        hit = 1;
        idx = i;
        off = AW'(av - m_base[i]);
      end
    end
  endfunction

  // ack_at: ds cycle on which the slave acks (0 = never). stray: every
  // unselected slave_ack bit is held high throughout the access.
  task automatic do_xfer(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int ack_at, input logic [DW-1:0] rd, input bit stray);
    bit hit;
    int idx;
    int cnt;
    int nh;
    bit done;
    bit exp_ack;
    logic [AW-1:0] off;
    logic [NS-1:0] exp_ds;
    model_decode(a, hit, idx, off);
    exp_ds  = hit ? (NS'(1) << idx) : '0;
    exp_ack = hit && ack_at >= 1 && ack_at <= TO;
    master_ds    = 1'b1;
    master_addr  = a;
    master_write = wd;
    step();
    n_cmp++;
    if (slave_ds !== exp_ds || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL decode addr=%h: ds=%b busy=%b, required ds=%b busy=1", a, slave_ds, busy, exp_ds);
    end
    cnt = 0;
    if (hit) begin
      done = 0;
      for (int c = 0; c < TO + 3 && !done; c++) begin
        if (master_ack || master_berr) begin
          done = 1;
        end else begin
          n_cmp++;
          if (slave_ds !== exp_ds || slave_addr !== off || slave_write !== wd) begin
            n_bad++;
            $display("FAIL access addr=%h: ds=%b saddr=%h swr=%h, required ds=%b saddr=%h swr=%h",
                     a, slave_ds, slave_addr, slave_write, exp_ds, off, wd);
          end
          cnt++;
          slave_read = {$urandom, $urandom};
          slave_read[idx*DW +: DW] = rd;
          slave_ack = stray ? ~exp_ds : '0;
          if (cnt == ack_at) slave_ack[idx] = 1'b1;
          step();
        end
      end
      slave_ack = '0;
      n_cmp++;
      if (exp_ack ? (cnt != ack_at) : (cnt != TO)) begin
        n_bad++;
        $display("FAIL ds_cycles addr=%h: %0d, required %0d", a, cnt, exp_ack ? ack_at : TO);
      end
      if (exp_ack) begin
        n_cmp++;
        if (master_read !== rd) begin
          n_bad++;
          $display("FAIL read_data addr=%h: %h, required %h", a, master_read, rd);
        end
        last_read = rd;
      end
    end
    nh = $urandom_range(0, 2);
    for (int h = 0; h <= nh; h++) begin
      n_cmp++;
      if (master_ack !== exp_ack || master_berr !== !exp_ack || slave_ds !== '0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL hold addr=%h: ack=%b berr=%b ds=%b busy=%b, required ack=%b berr=%b ds=0 busy=1",
                 a, master_ack, master_berr, slave_ds, busy, exp_ack, !exp_ack);
      end
      if (h < nh) step();
    end
    master_ds = 1'b0;
    step();
    n_cmp++;
    if (master_ack !== 1'b0 || master_berr !== 1'b0 || busy !== 1'b0 || slave_ds !== '0 ||
        master_read !== last_read) begin
      n_bad++;
      $display("FAIL release addr=%h: ack=%b berr=%b busy=%b ds=%b rd=%h, required 0 0 0 0 rd=%h",
               a, master_ack, master_berr, busy, slave_ds, master_read, last_read);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    master_ds = 1'b0;
    master_addr = '0;
    master_write = '0;
    slave_read = '0;
    slave_ack = '0;
    step();
    step();
    reset = 1'b0;
    last_read = '0;
    n_cmp++;
    if (slave_ds !== '0 || master_ack !== 1'b0 || master_berr !== 1'b0 || busy !== 1'b0 ||
        master_read !== '0 || slave_addr !== '0 || slave_write !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ds=%b ack=%b berr=%b busy=%b rd=%h saddr=%h swr=%h, required all zero",
               slave_ds, master_ack, master_berr, busy, master_read, slave_addr, slave_write);
    end
  endtask

  task automatic test_read_basic();
    do_xfer(32'h0000_0010, 16'h5A5A, 3, 16'hBEEF, 1'b0);
  endtask

  task automatic test_write_slave1();
    do_xfer(32'h0010_0104, 16'h1234, 2, 16'h0F0F, 1'b0);
  endtask

  task automatic test_unmapped();
    do_xfer(32'h0020_0000, 16'h1111, 1, 16'h2222, 1'b0);
    do_xfer(32'hFFFF_FFFF, 16'h3333, 1, 16'h4444, 1'b0);
    do_xfer(32'h0010_0300, 16'h5555, 1, 16'h6666, 1'b0);
  endtask

  task automatic test_timeout();
    do_xfer(32'h0010_0200, 16'hAAAA, 0, 16'h7777, 1'b0);
    do_xfer(32'h0010_0000, 16'hBBBB, TO, 16'hC0DE, 1'b0);
  endtask

  task automatic test_stray_ack();
    do_xfer(32'h0000_0040, 16'h0001, 4, 16'hD00D, 1'b1);
  endtask

  task automatic test_abort();
    int k;
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, TO - 2);
      master_ds = 1'b1;
      master_addr = 32'h0010_0100 + AW'($urandom_range(0, 255));
      master_write = DW'($urandom);
      slave_ack = '0;
      for (int c = 0; c < k; c++) step();
      master_ds = 1'b0;
      step();
      n_cmp++;
      if (slave_ds !== '0 || master_ack !== 1'b0 || master_berr !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort: ds=%b ack=%b berr=%b busy=%b, required all zero",
                 slave_ds, master_ack, master_berr, busy);
      end
      step();
      n_cmp++;
      if (master_ack !== 1'b0 || master_berr !== 1'b0 || master_read !== last_read) begin
        n_bad++;
        $display("FAIL abort_after: ack=%b berr=%b rd=%h, required 0 0 rd=%h",
                 master_ack, master_berr, master_read, last_read);
      end
    end
  endtask

  task automatic test_reset_mid();
    master_ds = 1'b1;
    master_addr = 32'h0000_0100;
    master_write = 16'h9999;
    step();
    step();
    reset = 1'b1;
    master_ds = 1'b0;
    step();
    reset = 1'b0;
    last_read = '0;
    n_cmp++;
    if (slave_ds !== '0 || master_ack !== 1'b0 || master_berr !== 1'b0 || busy !== 1'b0 ||
        master_read !== '0 || slave_addr !== '0 || slave_write !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: ds=%b ack=%b berr=%b busy=%b rd=%h saddr=%h swr=%h, required all zero",
               slave_ds, master_ack, master_berr, busy, master_read, slave_addr, slave_write);
    end
    step();
    n_cmp++;
    if (master_ack !== 1'b0 || master_berr !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_after: ack=%b berr=%b busy=%b, required 0 0 0", master_ack, master_berr, busy);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int r;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 4);
      if (r < NS) a = AW'(m_base[r] + 64'($urandom_range(0, 32'(m_size[r] - 1))));
      else a = 32'h0010_0300 + AW'($urandom_range(0, 32'h00FF_FFFF));
      do_xfer(a, DW'($urandom), $urandom_range(0, TO + 2), DW'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_read = '0;
    test_reset();
    test_read_basic();
    test_write_slave1();
    test_unmapped();
    test_timeout();
    test_stray_ack();
    test_abort();
    test_random();
    test_reset_mid();
    do_xfer(32'h0010_0110, 16'hFACE, 1, 16'hCAFE, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
